// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, instruction opcodes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct7 values that select the base / alternate R-type operation
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of opcode/funct3/funct7 into ALU op, illegal flag and branch outcome.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; consumer samples outputs on its own handshake.
// Ports: opcode/funct3/funct7 instruction fields, op_a/op_b operands for branch compare;
//        alu_ctrl decoded op (0000 when illegal), illegal, branch_taken, is_shift.
module alu_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_ctrl,
    output logic            illegal,
    output logic            branch_taken,
    output logic            is_shift
);

    logic [3:0] ctrl_raw;
    logic       bad;
    logic       cond;
    logic       f7_base;
    logic       f7_alt;
    logic       cmp_eq;
    logic       cmp_lt;
    logic       cmp_ltu;

    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);
    assign cmp_eq  = (op_a == op_b);
    assign cmp_lt  = ($signed(op_a) < $signed(op_b));
    assign cmp_ltu = (op_a < op_b);

    always_comb begin
        ctrl_raw = ALU_ADD;
        bad      = 1'b0;
        cond     = 1'b0;
        case (opcode)
            OPC_RTYPE, OPC_ITYPE: begin
                case (funct3)
                    3'b000: begin
                        ctrl_raw = f7_alt ? ALU_SUB : ALU_ADD;
                        bad      = !(f7_base || f7_alt);
                    end
                    3'b001: begin ctrl_raw = ALU_SLL;  bad = !f7_base; end
                    3'b010: begin ctrl_raw = ALU_SLT;  bad = !f7_base; end
                    3'b011: begin ctrl_raw = ALU_SLTU; bad = !f7_base; end
                    3'b100: begin ctrl_raw = ALU_XOR;  bad = !f7_base; end
                    3'b101: begin
                        ctrl_raw = f7_alt ? ALU_SRA : ALU_SRL;
                        bad      = !(f7_base || f7_alt);
                    end
                    3'b110: begin ctrl_raw = ALU_OR;   bad = !f7_base; end
                    default: begin ctrl_raw = ALU_AND; bad = !f7_base; end
                endcase
                // Immediate forms: funct7 carries immediate bits for ADDI,
                // and only bit 5 picks the shift flavour for SRLI/SRAI.
                if (opcode == OPC_ITYPE) begin
                    if (funct3 == 3'b000) begin
                        ctrl_raw = ALU_ADD;
                        bad      = 1'b0;
                    end else if (funct3 == 3'b101) begin
                        ctrl_raw = funct7[5] ? ALU_SRA : ALU_SRL;
                        bad      = 1'b0;
                    end
                end
            end
            OPC_LOAD, OPC_STORE: ctrl_raw = ALU_ADD;
            OPC_LUI:             ctrl_raw = ALU_PASSB;
            OPC_BRANCH: begin
                ctrl_raw = ALU_SUB;
                case (funct3)
                    3'b000:  cond = cmp_eq;
                    3'b001:  cond = !cmp_eq;
                    3'b100:  cond = cmp_lt;
                    3'b101:  cond = !cmp_lt;
                    3'b110:  cond = cmp_ltu;
                    3'b111:  cond = !cmp_ltu;
                    default: bad  = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
    end

    // An unsupported encoding collapses to a harmless all-zero operation
    assign illegal      = bad;
    assign alu_ctrl     = bad ? ALU_ADD : ctrl_raw;
    assign branch_taken = !bad && cond;
    assign is_shift     = !bad && is_shift_op(ctrl_raw);

endmodule

// File: rtl/alu_exec_unit.sv
// Integer ALU execute stage with registered outputs and optional bit-serial shifter.
// Latency: 1 cycle; serial shifts take 1+shamt cycles.
// Backpressure: result held in HOLD until out_ready; a new request is taken in the same cycle it drains.
// Ports: clk/rst (sync, active-high); in_valid/in_ready request; opcode/funct3/funct7/op_a/op_b;
//        out_valid/out_ready result; result, branch_taken, alu_ctrl, illegal (all registered).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic [3:0]      alu_ctrl,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    state_e          state;
    state_e          state_nxt;
    logic [SHW-1:0]  shamt;
    logic [SHW-1:0]  shcnt;
    logic [3:0]      dec_ctrl;
    logic            dec_illegal;
    logic            dec_branch;
    logic            dec_is_shift;
    logic            accept;
    logic            serial_start;
    logic [XLEN-1:0] alu_out;

    alu_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_ctrl     (dec_ctrl),
        .illegal      (dec_illegal),
        .branch_taken (dec_branch),
        .is_shift     (dec_is_shift)
    );

    assign shamt  = op_b[SHW-1:0];
    assign accept = in_valid && in_ready;
    // A zero-distance shift has nothing to iterate, so it completes like any other op
    assign serial_start = (SERIAL_SHIFT != 0) && dec_is_shift && (shamt != '0);

    always_comb begin
        alu_out = '0;
        case (dec_ctrl)
            ALU_ADD:   alu_out = op_a + op_b;
            ALU_SUB:   alu_out = op_a - op_b;
            ALU_AND:   alu_out = op_a & op_b;
            ALU_OR:    alu_out = op_a | op_b;
            ALU_XOR:   alu_out = op_a ^ op_b;
            ALU_SLL:   alu_out = op_a << shamt;
            ALU_SRL:   alu_out = op_a >> shamt;
            ALU_SRA:   alu_out = $signed(op_a) >>> shamt;
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: alu_out = op_b;
            default:   alu_out = '0;
        endcase
        if (dec_illegal) begin
            alu_out = '0;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = serial_start ? ST_BUSY : ST_HOLD;
                end
            end
            ST_BUSY: begin
                if (shcnt == SHW'(1)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_nxt = serial_start ? ST_BUSY : ST_HOLD;
                end else if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = (state == ST_HOLD);
        in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    end

    // Datapath: result doubles as the shift accumulator while BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            branch_taken <= 1'b0;
            alu_ctrl     <= 4'b0000;
            illegal      <= 1'b0;
            shcnt        <= '0;
        end else if (accept) begin
            alu_ctrl     <= dec_ctrl;
            illegal      <= dec_illegal;
            branch_taken <= dec_branch;
            if (serial_start) begin
                result <= op_a;
                shcnt  <= shamt;
            end else begin
                result <= alu_out;
                shcnt  <= '0;
            end
        end else if (state == ST_BUSY) begin
            shcnt <= shcnt - SHW'(1);
            case (alu_ctrl)
                ALU_SLL: result <= result << 1;
                ALU_SRL: result <= result >> 1;
                default: result <= {result[XLEN-1], result[XLEN-1:1]};
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_taken;
    logic [3:0]  alu_ctrl;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;

    alu_exec_unit #(
        .XLEN         (32),
        .SERIAL_SHIFT (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .alu_ctrl     (alu_ctrl),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        op_a     = a;
        op_b     = b;
    endtask

    // Present a request in IDLE, take the accepting edge, then drop in_valid
    task automatic issue(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        drive(opc, f3, f7, a, b);
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from acceptance until out_valid is seen (1 = next cycle), bounded
    task automatic wait_out(output int l);
        l = 1;
        while (out_valid !== 1'b1 && l < 64) begin
            tick();
            l++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        funct3    = '0;
        funct7    = '0;
        op_a      = '0;
        op_b      = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_branch", branch_taken, 0);

        // ADD 5+7
        issue("add", 7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7);
        wait_out(lat);
        chk("add_latency", lat, 1);
        chk("add_result", result, 12);
        chk("add_illegal", illegal, 0);
        chk("add_ctrl", alu_ctrl, 4'b0000);
        tick();
        chk("add_drained", out_valid, 0);

        // SUB 3-5 under backpressure
        out_ready = 1'b0;
        issue("sub", 7'b0110011, 3'b000, 7'b0100000, 32'd3, 32'd5);
        wait_out(lat);
        chk("sub_latency", lat, 1);
        chk("sub_result", result, 32'hFFFF_FFFE);
        chk("sub_ctrl", alu_ctrl, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sub_hold_valid", out_valid, 1);
            chk("sub_hold_result", result, 32'hFFFF_FFFE);
            chk("sub_hold_ctrl", alu_ctrl, 4'b0001);
            chk("sub_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("sub_drained", out_valid, 0);

        // Back-to-back AND then XOR, second accepted while first drains
        issue("and", 7'b0110011, 3'b111, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00);
        wait_out(lat);
        chk("and_latency", lat, 1);
        chk("and_result", result, 32'h0000_F000);
        drive(7'b0110011, 3'b100, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00);
        chk("xor_in_ready_in_hold", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("xor_b2b_valid", out_valid, 1);
        chk("xor_result", result, 32'h0000_0FF0);
        chk("xor_ctrl", alu_ctrl, 4'b0100);
        tick();

        // Serial SRA by 4
        issue("sra4", 7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4);
        chk("sra4_busy_in_ready", in_ready, 0);
        chk("sra4_busy_valid", out_valid, 0);
        wait_out(lat);
        chk("sra4_latency", lat, 5);
        chk("sra4_result", result, 32'hF800_0000);
        chk("sra4_ctrl", alu_ctrl, 4'b0111);
        tick();

        // SRA by 0 completes in one cycle
        issue("sra0", 7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0);
        wait_out(lat);
        chk("sra0_latency", lat, 1);
        chk("sra0_result", result, 32'h8000_0000);
        tick();

        // SLLI: only the low 5 bits of op_b are the shift amount (0x25 -> 5)
        issue("slli", 7'b0010011, 3'b001, 7'b0000000, 32'd1, 32'h25);
        wait_out(lat);
        chk("slli_latency", lat, 6);
        chk("slli_result", result, 32'h20);
        chk("slli_ctrl", alu_ctrl, 4'b0101);
        tick();

        // SLT / SLTU signedness
        issue("slt", 7'b0110011, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1);
        wait_out(lat);
        chk("slt_result", result, 1);
        chk("slt_ctrl", alu_ctrl, 4'b1000);
        tick();
        issue("sltu", 7'b0110011, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1);
        wait_out(lat);
        chk("sltu_result", result, 0);
        chk("sltu_ctrl", alu_ctrl, 4'b1001);
        tick();

        // LUI passes op_b
        issue("lui", 7'b0110111, 3'b000, 7'b0000000, 32'hDEAD_BEEF, 32'h1234_5000);
        wait_out(lat);
        chk("lui_result", result, 32'h1234_5000);
        chk("lui_ctrl", alu_ctrl, 4'b1010);
        chk("lui_branch", branch_taken, 0);
        tick();

        // Branches
        issue("blt", 7'b1100011, 3'b100, 7'b0000000, 32'hFFFF_FFFF, 32'd1);
        wait_out(lat);
        chk("blt_taken", branch_taken, 1);
        chk("blt_ctrl", alu_ctrl, 4'b0001);
        chk("blt_result", result, 32'hFFFF_FFFE);
        tick();
        issue("bltu", 7'b1100011, 3'b110, 7'b0000000, 32'hFFFF_FFFF, 32'd1);
        wait_out(lat);
        chk("bltu_taken", branch_taken, 0);
        tick();
        issue("beq", 7'b1100011, 3'b000, 7'b0000000, 32'd5, 32'd5);
        wait_out(lat);
        chk("beq_taken", branch_taken, 1);
        chk("beq_result", result, 0);
        tick();

        // Illegal opcode
        issue("ill_opc", 7'b1111111, 3'b000, 7'b0000000, 32'd5, 32'd7);
        wait_out(lat);
        chk("ill_opc_latency", lat, 1);
        chk("ill_opc_flag", illegal, 1);
        chk("ill_opc_result", result, 0);
        chk("ill_opc_ctrl", alu_ctrl, 0);
        chk("ill_opc_branch", branch_taken, 0);
        tick();
        chk("ill_opc_drained", out_valid, 0);

        // Illegal funct7 on R-type
        issue("ill_f7", 7'b0110011, 3'b000, 7'b0000001, 32'd5, 32'd7);
        wait_out(lat);
        chk("ill_f7_flag", illegal, 1);
        chk("ill_f7_result", result, 0);
        tick();

        // Reset while a serial shift is in BUSY
        issue("busy_sll", 7'b0110011, 3'b001, 7'b0000000, 32'd1, 32'd10);
        tick();
        tick();
        chk("busy_sll_valid", out_valid, 0);
        chk("busy_sll_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("busy_rst_valid", out_valid, 0);
        chk("busy_rst_in_ready", in_ready, 1);
        chk("busy_rst_result", result, 0);
        chk("busy_rst_ctrl", alu_ctrl, 0);
        chk("busy_rst_illegal", illegal, 0);
        chk("busy_rst_branch", branch_taken, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        chk("busy_rst_no_output", seen, 0);

        // Reset wins over a simultaneous request
        rst = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        chk("rst_prio_valid", out_valid, 0);
        chk("rst_prio_result", result, 0);
        tick();
        chk("rst_prio_not_accepted", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
